fpu_issue_ctrl: RTL and testbench

- Sequences the multi-cycle floating-point unit and drives the active-low load enables of the pipeline registers around it.
- On an FP issue it starts the FPU and holds upstream pipeline registers (enable_n=1 → hold, 0 → load) for the op's fixed latency.
- It then pulses a result-capture enable into the writeback register.
- Sits between decode/issue and the FPU datapath. The FPU has one outstanding op at a time.

---
 rtl/fpu_ctrl_pkg.sv | 50 +++++
 rtl/lat_down_counter.sv | 39 +++
 rtl/fpu_issue_ctrl.sv | 148 ++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_ctrl_pkg.sv
// fpu_ctrl_pkg
// Shared types and helpers for the FP issue controller:
//   fp_op_e      - 3-bit op class presented at issue and to the FPU
//   ctrl_state_e - issue controller FSM states
//   op_latency() - maps an op class to its fixed FPU latency in cycles
package fpu_ctrl_pkg;

  localparam logic [2:0] OP_RESERVED = 3'd7;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_DIV  = 3'd3,
    OP_SQRT = 3'd4,
    OP_CVT  = 3'd5,
    OP_CMP  = 3'd6,
    OP_RSVD = 3'd7
  } fp_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } ctrl_state_e;

  // The reserved op still occupies the FPU slot for one cycle so the
  // pipeline sees a normal single-cycle handshake alongside illegal_op.
  // The caller narrows the result to its counter width.
  function automatic int unsigned op_latency(
    input fp_op_e      op,
    input int unsigned lat_add,
    input int unsigned lat_mul,
    input int unsigned lat_div,
    input int unsigned lat_sqrt,
    input int unsigned lat_cvt,
    input int unsigned lat_cmp
  );
    case (op)
      OP_ADD, OP_SUB: return lat_add;
      OP_MUL:         return lat_mul;
      OP_DIV:         return lat_div;
      OP_SQRT:        return lat_sqrt;
      OP_CVT:         return lat_cvt;
      OP_CMP:         return lat_cmp;
      default:        return 1;
    endcase
  endfunction

endpackage

// File: rtl/lat_down_counter.sv
// lat_down_counter
// Loadable down-counter that tracks the remaining FPU latency.
// Ports:
//   clk50M   - clock, rising edge
//   rst      - asynchronous active-low reset
//   load     - load load_val (clr has priority)
//   load_val - value loaded on load
//   dec      - decrement by one; saturates at zero, never wraps
//   clr      - synchronous clear to zero
//   cnt      - current count
//   is_one   - cnt == 1, i.e. the last held cycle
module lat_down_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk50M,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             is_one
);

  always_ff @(posedge clk50M or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign is_one = (cnt == CNT_W'(1));

endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl
// Sequences the multi-cycle FPU: starts an op, holds the upstream pipeline
// registers for the op's fixed latency, then pulses the writeback enable.
// One op in flight at a time.
// Ports:
//   clk50M      - clock, rising edge
//   rst         - asynchronous active-low reset
//   issue_valid - FP instruction present at issue
//   issue_op    - op class (fp_op_e)
//   flush       - pipeline flush, kills an in-flight op
//   fpu_start   - one-cycle start pulse to the FPU
//   fpu_op      - registered op class, stable while busy
//   fpu_abort   - one-cycle pulse when an in-flight op is killed
//   pipe_en_n   - active-low upstream load enable (1 = hold)
//   wb_en_n     - active-low result register enable, one cycle per op
//   busy        - op in flight
//   illegal_op  - one-cycle pulse when the reserved op is accepted
//
// state | meaning
// IDLE  | no op in flight; accepts issue_valid when not flushing
// BUSY  | FPU working; upstream held, counter running down
// DONE  | result cycle; writeback pulse, upstream released
module fpu_issue_ctrl
  import fpu_ctrl_pkg::*;
#(
  parameter int LAT_ADD  = 3,
  parameter int LAT_MUL  = 4,
  parameter int LAT_DIV  = 12,
  parameter int LAT_SQRT = 16,
  parameter int LAT_CVT  = 2,
  parameter int LAT_CMP  = 1,
  parameter int CNT_W    = 5
) (
  input  logic       clk50M,
  input  logic       rst,
  input  logic       issue_valid,
  input  logic [2:0] issue_op,
  input  logic       flush,
  output logic       fpu_start,
  output logic [2:0] fpu_op,
  output logic       fpu_abort,
  output logic       pipe_en_n,
  output logic       wb_en_n,
  output logic       busy,
  output logic       illegal_op
);

  localparam int LAT_MAX = (1 << CNT_W) - 1;

  if (LAT_ADD  < 1 || LAT_ADD  > LAT_MAX ||
      LAT_MUL  < 1 || LAT_MUL  > LAT_MAX ||
      LAT_DIV  < 1 || LAT_DIV  > LAT_MAX ||
      LAT_SQRT < 1 || LAT_SQRT > LAT_MAX ||
      LAT_CVT  < 1 || LAT_CVT  > LAT_MAX ||
      LAT_CMP  < 1 || LAT_CMP  > LAT_MAX) begin : g_bad_latency
    $error("fpu_issue_ctrl: every LAT_* must be in 1..2^CNT_W-1");
  end

  ctrl_state_e      state, state_nx;
  logic             accept;
  logic [CNT_W-1:0] lat;
  logic [CNT_W-1:0] cnt;
  logic             cnt_is_one;
  logic             cnt_load, cnt_dec, cnt_clr;

  assign lat = CNT_W'(op_latency(fp_op_e'(issue_op),
                                 LAT_ADD, LAT_MUL, LAT_DIV,
                                 LAT_SQRT, LAT_CVT, LAT_CMP));

  assign accept = (state == ST_IDLE) && issue_valid && !flush;

  lat_down_counter #(.CNT_W(CNT_W)) u_lat_cnt (
    .clk50M   (clk50M),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (lat - CNT_W'(1)),
    .dec      (cnt_dec),
    .clr      (cnt_clr),
    .cnt      (cnt),
    .is_one   (cnt_is_one)
  );

  always_ff @(posedge clk50M or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      fpu_op <= 3'd0;
    end else begin
      state <= state_nx;
      if (accept) begin
        fpu_op <= issue_op;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    fpu_start  = 1'b0;
    fpu_abort  = 1'b0;
    busy       = 1'b0;
    illegal_op = 1'b0;
    pipe_en_n  = 1'b0;
    wb_en_n    = 1'b1;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    cnt_clr    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          fpu_start  = 1'b1;
          pipe_en_n  = 1'b1;
          cnt_load   = 1'b1;
          illegal_op = (issue_op == OP_RESERVED);
          state_nx   = (lat > CNT_W'(1)) ? ST_BUSY : ST_DONE;
        end
      end
      ST_BUSY: begin
        busy = 1'b1;
        if (flush) begin
          fpu_abort = 1'b1;
          cnt_clr   = 1'b1;
          state_nx  = ST_IDLE;
        end else begin
          pipe_en_n = 1'b1;
          cnt_dec   = 1'b1;
          // A zero count here cannot arise from a legal load; leaving
          // anyway keeps the FSM from sticking in BUSY.
          if (cnt_is_one || (cnt == '0)) begin
            state_nx = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        busy     = 1'b1;
        cnt_clr  = 1'b1;
        state_nx = ST_IDLE;
        if (flush) begin
          fpu_abort = 1'b1;
        end else begin
          wb_en_n = 1'b0;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
module tb_fpu_issue_ctrl;

  logic       clk50M = 1'b0;
  logic       rst = 1'b0;
  logic       issue_valid = 1'b0;
  logic [2:0] issue_op = 3'd0;
  logic       flush = 1'b0;
  logic       fpu_start;
  logic [2:0] fpu_op;
  logic       fpu_abort;
  logic       pipe_en_n;
  logic       wb_en_n;
  logic       busy;
  logic       illegal_op;

  int n_vec = 0;
  int n_err = 0;

  fpu_issue_ctrl dut (
    .clk50M      (clk50M),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_op    (issue_op),
    .flush       (flush),
    .fpu_start   (fpu_start),
    .fpu_op      (fpu_op),
    .fpu_abort   (fpu_abort),
    .pipe_en_n   (pipe_en_n),
    .wb_en_n     (wb_en_n),
    .busy        (busy),
    .illegal_op  (illegal_op)
  );

  always #10 clk50M = ~clk50M;

  // Apply inputs for one cycle at the falling edge; outputs settle by #1.
  task automatic drive(input logic v, input logic [2:0] op, input logic f);
    @(negedge clk50M);
    issue_valid = v;
    issue_op    = op;
    flush       = f;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    n_vec++;
    if ({fpu_start, fpu_abort, busy, illegal_op, pipe_en_n, wb_en_n, fpu_op} !== {6'b000001, 3'd0}) begin
      n_err++;
      $display("FAIL reset_outputs: got start=%b abort=%b busy=%b ill=%b pen=%b wb=%b op=%0d, want 0 0 0 0 0 1 0",
               fpu_start, fpu_abort, busy, illegal_op, pipe_en_n, wb_en_n, fpu_op);
    end
    @(negedge clk50M);
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 3'd0, 1'b0);
      n_vec++;
      if ({pipe_en_n, wb_en_n, busy, fpu_start} !== 4'b0100) begin
        n_err++;
        $display("FAIL reset_idle[%0d]: got pen=%b wb=%b busy=%b start=%b, want 0 1 0 0",
                 k, pipe_en_n, wb_en_n, busy, fpu_start);
      end
    end
  endtask

  task automatic test_mul();
    logic exp_pen, exp_wb, exp_busy;
    drive(1'b1, 3'd2, 1'b0);
    n_vec++;
    if ({fpu_start, pipe_en_n, busy, wb_en_n} !== 4'b1101) begin
      n_err++;
      $display("FAIL mul_accept: got start=%b pen=%b busy=%b wb=%b, want 1 1 0 1",
               fpu_start, pipe_en_n, busy, wb_en_n);
    end
    for (int k = 1; k <= 5; k++) begin
      drive(1'b0, 3'd0, 1'b0);
      exp_pen  = (k <= 3);
      exp_wb   = (k != 4);
      exp_busy = (k <= 4);
      n_vec++;
      if ({fpu_start, pipe_en_n, wb_en_n, busy} !== {1'b0, exp_pen, exp_wb, exp_busy}) begin
        n_err++;
        $display("FAIL mul_T+%0d: got start=%b pen=%b wb=%b busy=%b, want 0 %b %b %b",
                 k, fpu_start, pipe_en_n, wb_en_n, busy, exp_pen, exp_wb, exp_busy);
      end
      if (k == 1) begin
        n_vec++;
        if (fpu_op !== 3'd2) begin
          n_err++;
          $display("FAIL mul_fpu_op: got %0d, want 2", fpu_op);
        end
      end
    end
  endtask

  task automatic test_back_to_back_cmp();
    drive(1'b1, 3'd6, 1'b0);
    n_vec++;
    if ({fpu_start, pipe_en_n, wb_en_n} !== 3'b111) begin
      n_err++;
      $display("FAIL cmp_accept: got start=%b pen=%b wb=%b, want 1 1 1", fpu_start, pipe_en_n, wb_en_n);
    end
    // T+1: straight to DONE, issue_valid ignored
    drive(1'b1, 3'd6, 1'b0);
    n_vec++;
    if ({fpu_start, pipe_en_n, wb_en_n, busy} !== 4'b0001) begin
      n_err++;
      $display("FAIL cmp_done: got start=%b pen=%b wb=%b busy=%b, want 0 0 0 1",
               fpu_start, pipe_en_n, wb_en_n, busy);
    end
    // T+2: second CMP accepted
    drive(1'b1, 3'd6, 1'b0);
    n_vec++;
    if ({fpu_start, busy, wb_en_n} !== 3'b101) begin
      n_err++;
      $display("FAIL cmp_second_accept: got start=%b busy=%b wb=%b, want 1 0 1", fpu_start, busy, wb_en_n);
    end
    drive(1'b0, 3'd0, 1'b0);
    n_vec++;
    if ({wb_en_n, fpu_start} !== 2'b00) begin
      n_err++;
      $display("FAIL cmp_second_wb: got wb=%b start=%b, want 0 0", wb_en_n, fpu_start);
    end
    drive(1'b0, 3'd0, 1'b0);
    n_vec++;
    if ({wb_en_n, busy} !== 2'b10) begin
      n_err++;
      $display("FAIL cmp_idle: got wb=%b busy=%b, want 1 0", wb_en_n, busy);
    end
  endtask

  task automatic test_div_flush();
    drive(1'b1, 3'd3, 1'b0);
    n_vec++;
    if (fpu_start !== 1'b1) begin
      n_err++;
      $display("FAIL div_start: got %b, want 1", fpu_start);
    end
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, 3'd0, 1'b0);
      n_vec++;
      if ({busy, pipe_en_n, fpu_abort} !== 3'b110) begin
        n_err++;
        $display("FAIL div_busy_T+%0d: got busy=%b pen=%b abort=%b, want 1 1 0", k, busy, pipe_en_n, fpu_abort);
      end
    end
    drive(1'b0, 3'd0, 1'b1);
    n_vec++;
    if ({fpu_abort, pipe_en_n, wb_en_n} !== 3'b101) begin
      n_err++;
      $display("FAIL div_flush: got abort=%b pen=%b wb=%b, want 1 0 1", fpu_abort, pipe_en_n, wb_en_n);
    end
    for (int k = 6; k <= 20; k++) begin
      drive(1'b0, 3'd0, 1'b0);
      n_vec++;
      if ({wb_en_n, busy, fpu_abort, pipe_en_n} !== 4'b1000) begin
        n_err++;
        $display("FAIL div_after_flush_T+%0d: got wb=%b busy=%b abort=%b pen=%b, want 1 0 0 0",
                 k, wb_en_n, busy, fpu_abort, pipe_en_n);
      end
    end
  endtask

  task automatic test_flush_in_done();
    drive(1'b1, 3'd0, 1'b0);
    drive(1'b0, 3'd0, 1'b0);
    drive(1'b0, 3'd0, 1'b0);
    drive(1'b0, 3'd0, 1'b1);
    n_vec++;
    if ({busy, wb_en_n, fpu_abort} !== 3'b111) begin
      n_err++;
      $display("FAIL done_flush: got busy=%b wb=%b abort=%b, want 1 1 1", busy, wb_en_n, fpu_abort);
    end
    drive(1'b0, 3'd0, 1'b0);
    n_vec++;
    if ({busy, wb_en_n, fpu_abort} !== 3'b010) begin
      n_err++;
      $display("FAIL done_flush_idle: got busy=%b wb=%b abort=%b, want 0 1 0", busy, wb_en_n, fpu_abort);
    end
  endtask

  task automatic test_flush_issue_illegal();
    drive(1'b1, 3'd1, 1'b1);
    n_vec++;
    if ({fpu_start, pipe_en_n} !== 2'b00) begin
      n_err++;
      $display("FAIL flush_issue: got start=%b pen=%b, want 0 0", fpu_start, pipe_en_n);
    end
    drive(1'b0, 3'd0, 1'b0);
    n_vec++;
    if ({fpu_start, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL flush_issue_after: got start=%b busy=%b, want 0 0", fpu_start, busy);
    end
    drive(1'b1, 3'd7, 1'b0);
    n_vec++;
    if ({illegal_op, fpu_start, pipe_en_n} !== 3'b111) begin
      n_err++;
      $display("FAIL illegal_accept: got ill=%b start=%b pen=%b, want 1 1 1", illegal_op, fpu_start, pipe_en_n);
    end
    drive(1'b0, 3'd0, 1'b0);
    n_vec++;
    if ({wb_en_n, illegal_op, fpu_op} !== {2'b00, 3'd7}) begin
      n_err++;
      $display("FAIL illegal_wb: got wb=%b ill=%b op=%0d, want 0 0 7", wb_en_n, illegal_op, fpu_op);
    end
    drive(1'b0, 3'd0, 1'b0);
    n_vec++;
    if ({wb_en_n, busy} !== 2'b10) begin
      n_err++;
      $display("FAIL illegal_idle: got wb=%b busy=%b, want 1 0", wb_en_n, busy);
    end
  endtask

  task automatic test_reset_mid_sqrt();
    drive(1'b1, 3'd4, 1'b0);
    for (int k = 1; k <= 8; k++) drive(1'b0, 3'd0, 1'b0);
    n_vec++;
    if ({busy, pipe_en_n} !== 2'b11) begin
      n_err++;
      $display("FAIL sqrt_busy_T+8: got busy=%b pen=%b, want 1 1", busy, pipe_en_n);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if ({fpu_start, fpu_abort, busy, illegal_op, pipe_en_n, wb_en_n, fpu_op} !== {6'b000001, 3'd0}) begin
      n_err++;
      $display("FAIL sqrt_async_reset: got start=%b abort=%b busy=%b ill=%b pen=%b wb=%b op=%0d, want 0 0 0 0 0 1 0",
               fpu_start, fpu_abort, busy, illegal_op, pipe_en_n, wb_en_n, fpu_op);
    end
    drive(1'b0, 3'd0, 1'b0);
    n_vec++;
    if ({fpu_abort, wb_en_n, busy} !== 3'b010) begin
      n_err++;
      $display("FAIL sqrt_in_reset: got abort=%b wb=%b busy=%b, want 0 1 0", fpu_abort, wb_en_n, busy);
    end
    rst = 1'b1;
    drive(1'b1, 3'd0, 1'b0);
    n_vec++;
    if (fpu_start !== 1'b1) begin
      n_err++;
      $display("FAIL add_after_reset_start: got %b, want 1", fpu_start);
    end
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, 3'd0, 1'b0);
      n_vec++;
      if ({pipe_en_n, wb_en_n, busy} !== {(k <= 2), (k != 3), (k <= 3)}) begin
        n_err++;
        $display("FAIL add_after_reset_T+%0d: got pen=%b wb=%b busy=%b, want %b %b %b",
                 k, pipe_en_n, wb_en_n, busy, (k <= 2), (k != 3), (k <= 3));
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_back_to_back_cmp();
    test_div_flush();
    test_flush_in_done();
    test_flush_issue_illegal();
    test_reset_mid_sqrt();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
